// File: rtl/sr_drive_sequencer_if.sv
// Command channel of sr_drive_sequencer: valid/ready handshake carrying a set/clear
// opcode and a pulse length.
interface sr_drive_sequencer_if #(
    parameter int unsigned HOLD_W = 8
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [HOLD_W-1:0] cmd_len;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_len,
        output cmd_ready
    );
endinterface

// File: rtl/sr_drive_sequencer.sv
// Queued set/clear driver for the library SR flip-flop; emits s-only or r-only pulses.
// Optional build macro SR_DRV_SKIP_REDUNDANT_EN drops commands that would not change q.
module sr_drive_sequencer #(
    parameter int unsigned HOLD_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned GAP    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    sr_drive_sequencer_if.slave    cmd,
    output logic                   s,
    output logic                   r,
    output logic                   busy,
    output logic                   q_shadow,
    output logic [$clog2(DEPTH):0] fifo_cnt
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    // Wide enough to hold GAP and still legal when GAP is 0
    localparam int unsigned GapW = $clog2(GAP + 2);

    localparam logic [CntW-1:0]   FullCnt = CntW'(DEPTH);
    localparam logic [CntW-1:0]   CntOne  = CntW'(1);
    localparam logic [PtrW-1:0]   PtrOne  = PtrW'(1);
    localparam logic [HOLD_W-1:0] HoldOne = HOLD_W'(1);
    localparam logic [GapW-1:0]   GapOne  = GapW'(1);
    localparam logic [GapW-1:0]   GapInit = GapW'(GAP);

    typedef enum logic [1:0] {StIdle, StPulse, StGap} state_e;

    state_e            state_q, state_d;

    logic              op_mem  [DEPTH];
    logic [HOLD_W-1:0] len_mem [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic              push, pop, fifo_empty;
    logic              head_op;
    logic [HOLD_W-1:0] head_len;

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
    logic              s_q, s_d, r_q, r_d;
    logic              q_shadow_q;
    logic              skip;

    // ---------------------------------------------------------------- command FIFO
    assign cmd.cmd_ready = (fifo_cnt_q < FullCnt);
    assign push          = cmd.cmd_valid & cmd.cmd_ready;
    assign fifo_empty    = (fifo_cnt_q == '0);
    assign head_op       = op_mem[rd_ptr_q];
    assign head_len      = len_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            op_mem[wr_ptr_q]  <= cmd.cmd_op;
            len_mem[wr_ptr_q] <= cmd.cmd_len;
        end
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CntOne;
        end else if (!push && pop) begin
            fifo_cnt_d = fifo_cnt_q - CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // ---------------------------------------------------------------- redundancy filter
`ifdef SR_DRV_SKIP_REDUNDANT_EN
    logic shadow_valid_q;

    // The shadow only means something once a pulse has actually reached the flip-flop
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_valid_q <= 1'b0;
        end else if (s_q || r_q) begin
            shadow_valid_q <= 1'b1;
        end
    end

    assign skip = shadow_valid_q & (head_op == q_shadow_q);
`else
    assign skip = 1'b0;
`endif

    // ---------------------------------------------------------------- FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            q_shadow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            s_q        <= s_d;
            r_q        <= r_d;
            // Mirrors the flip-flop: it captures whichever drive was high last cycle
            if (s_q || r_q) begin
                q_shadow_q <= s_q;
            end
        end
    end

    // ---------------------------------------------------------------- FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && !skip) begin
                    state_d = StPulse;
                end
            end
            StPulse: begin
                if (hold_cnt_q == HoldOne) begin
                    state_d = (GAP == 0) ? StIdle : StGap;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapOne) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- FSM outputs
    always_comb begin
        pop        = 1'b0;
        s_d        = 1'b0;
        r_d        = 1'b0;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (!skip) begin
                        s_d        = head_op;
                        r_d        = ~head_op;
                        hold_cnt_d = (head_len == '0) ? HoldOne : head_len;
                    end
                end
            end
            StPulse: begin
                if (hold_cnt_q == HoldOne) begin
                    gap_cnt_d = GapInit;
                end else begin
                    s_d        = s_q;
                    r_d        = r_q;
                    hold_cnt_d = hold_cnt_q - HoldOne;
                end
            end
            StGap: begin
                gap_cnt_d = gap_cnt_q - GapOne;
            end
            default: ;
        endcase
    end

    assign s        = s_q;
    assign r        = r_q;
    assign q_shadow = q_shadow_q;
    assign fifo_cnt = fifo_cnt_q;
    assign busy     = !fifo_empty || (state_q != StIdle);
endmodule

// File: tb/tb_sr_drive_sequencer.sv
// Randomized bench for sr_drive_sequencer against a schedule-level reference model.
module tb_sr_drive_sequencer;
    localparam int unsigned HOLD_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned GAP    = 1;
`ifdef SR_DRV_SKIP_REDUNDANT_EN
    localparam bit SkipEn = 1'b1;
`else
    localparam bit SkipEn = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   s, r, busy, q_shadow;
    logic [$clog2(DEPTH):0] fifo_cnt;

    sr_drive_sequencer_if #(.HOLD_W(HOLD_W)) cmd_if ();

    sr_drive_sequencer #(
        .HOLD_W (HOLD_W),
        .DEPTH  (DEPTH),
        .GAP    (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd_if),
        .s        (s),
        .r        (r),
        .busy     (busy),
        .q_shadow (q_shadow),
        .fifo_cnt (fifo_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit op;
        int len;
    } cmd_t;

    // Model: pending commands plus the schedule of the most recent pulse
    cmd_t mq[$];
    int   k;            // edges since the model began
    int   ready_edge;   // earliest edge at which a pop may happen
    int   p_start, p_len;
    bit   p_op;
    bit   m_qs, m_sv;

    int   n_vec, n_err, n_acc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    task automatic check_outputs();
        bit act;
        act = (k >= p_start) && (k < p_start + p_len);
        check_eq("s", s, act && p_op);
        check_eq("r", r, act && !p_op);
        check_eq("s_and_r", s & r, 1'b0);
        check_eq("q_shadow", q_shadow, m_qs);
        check_eq("cmd_ready", cmd_if.cmd_ready, mq.size() < DEPTH);
        check_eq("fifo_cnt", fifo_cnt, mq.size());
        check_eq("busy", busy, (mq.size() != 0) || (k < ready_edge - 1));
    endtask

    task automatic model_step(input bit rst_in, input bit v, input bit op, input int len);
        int   e;
        bit   do_push, qs_n, sv_n;
        cmd_t c;
        e = k + 1;
        if (rst_in) begin
            mq.delete();
            ready_edge = e + 1;
            p_start    = 0;
            p_len      = 0;
            m_qs       = 1'b0;
            m_sv       = 1'b0;
            k          = e;
            return;
        end
        qs_n = m_qs;
        sv_n = m_sv;
        if (k >= p_start && k < p_start + p_len) begin
            qs_n = p_op;
            sv_n = 1'b1;
        end
        do_push = v && (mq.size() < DEPTH);
        if (mq.size() != 0 && e >= ready_edge) begin
            c = mq.pop_front();
            if (SkipEn && m_sv && (c.op == m_qs)) begin
                ready_edge = e + 1;
            end else begin
                p_start    = e;
                p_len      = (c.len == 0) ? 1 : c.len;
                p_op       = c.op;
                ready_edge = e + p_len + GAP + 1;
            end
        end
        if (do_push) begin
            c.op  = op;
            c.len = len;
            mq.push_back(c);
        end
        m_qs = qs_n;
        m_sv = sv_n;
        k    = e;
    endtask

    task automatic step(input bit rst_in, input bit v, input bit op, input int len);
        logic [31:0] len_bits;
        @(negedge clk);
        check_outputs();
        len_bits         = len;
        rst              = rst_in;
        cmd_if.cmd_valid = v;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_len   = len_bits[HOLD_W-1:0];
        if (v && !rst_in && cmd_if.cmd_ready) n_acc++;
        model_step(rst_in, v, op, len);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 1'b0;
        cmd_if.cmd_len   = '0;
        n_vec = 0;
        n_err = 0;
        n_acc = 0;
        k          = 0;
        ready_edge = 1;
        p_start    = 0;
        p_len      = 0;
        p_op       = 1'b0;
        m_qs       = 1'b0;
        m_sv       = 1'b0;
        repeat (2) @(posedge clk);

        idle(3);

        // Single set, length 3
        step(1'b0, 1'b1, 1'b1, 3);
        idle(8);

        // Back-to-back set/clear/set with a zero length
        step(1'b0, 1'b1, 1'b1, 2);
        step(1'b0, 1'b1, 1'b0, 1);
        step(1'b0, 1'b1, 1'b1, 0);
        idle(14);
        check_eq("mix_q_final", q_shadow, 1'b1);

        // Full FIFO: valid held for 6 cycles
        n_acc = 0;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 5);
        check_eq("full_accepts", n_acc, 5);
        idle(45);

        // Reset in the middle of a long pulse with commands queued
        step(1'b0, 1'b1, 1'b1, 10);
        step(1'b0, 1'b1, 1'b0, 3);
        step(1'b0, 1'b1, 1'b1, 3);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 0);
        idle(12);
        check_eq("post_reset_cnt", fifo_cnt, 0);

        // Redundant set in the middle
        step(1'b0, 1'b1, 1'b1, 2);
        step(1'b0, 1'b1, 1'b1, 4);
        step(1'b0, 1'b1, 1'b0, 1);
        idle(16);

        // Maximum length pulse
        step(1'b0, 1'b1, 1'b0, 255);
        idle(262);

        for (int i = 0; i < 1500; i++) begin
            bit rb, vb, ob;
            int ln;
            rb = ($urandom_range(0, 199) == 0);
            vb = ($urandom_range(0, 1) == 1);
            ob = ($urandom_range(0, 1) == 1);
            ln = ($urandom_range(0, 63) == 0) ? 255 : int'($urandom_range(0, 6));
            step(rb, vb, ob, ln);
        end

        idle(300);
        @(negedge clk);
        check_outputs();
        check_eq("drained_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
